sqroot_stream_stage: RTL and testbench

- Registered streaming front/back end for the combinational square-root block (sqroot_comb_NBITS8 in the 8-bit build).
- Upstream side: buffers (arg, roundup) requests in a small FIFO and drives the FIFO head onto the root's arg/roundup inputs.
- Downstream side: captures the root's sqroot result, with the echoed arg, into an output register under a valid/ready handshake.
- Adds flow control and timing isolation around the combinational root without changing its result.

---
 rtl/sqroot_pkg.sv | 18 +
 rtl/sqroot_comb_NBITS8.sv | 35 +++
 rtl/sqroot_req_fifo.sv | 66 ++++++
 rtl/sqroot_stream_stage.sv | 91 +++++++++
 tb/tb_sqroot_stream_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqroot_pkg.sv
// Shared definitions for the square-root streaming stage.
// Holds the default operand width, the root-width helper and the request record.
// Imported by the request FIFO, the stage top and the bench.
package sqroot_pkg;

    localparam int SQ_NBITS = 8;

    // A rounded-up root of an n-bit operand needs one bit more than half of n.
    function automatic int root_w(input int n);
        return n / 2 + 1;
    endfunction

    typedef struct packed {
        logic                roundup;
        logic [SQ_NBITS-1:0] arg;
    } sqroot_req_t;

endpackage

// File: rtl/sqroot_comb_NBITS8.sv
// Combinational 8-bit integer square root, floor or round-to-nearest.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the result follows the inputs in the same cycle.
module sqroot_comb_NBITS8 (
    input  logic [7:0] arg,
    input  logic       roundup,
    output logic [4:0] sqroot
);

    logic [9:0] rem;
    logic [9:0] trial;
    logic [4:0] res;
    logic       inc;

    // Digit-by-digit root: two operand bits per step, remainder kept for rounding.
    always_comb begin
        rem   = '0;
        res   = '0;
        trial = '0;
        for (int i = 3; i >= 0; i--) begin
            rem   = {rem[7:0], arg[2*i+1 -: 2]};
            trial = {3'b000, res, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                res = {res[3:0], 1'b1};
            end else begin
                res = {res[3:0], 1'b0};
            end
        end
        // arg >= (r+0.5)^2 exactly when the remainder exceeds r.
        inc    = roundup && (rem > {5'b00000, res});
        sqroot = res + {4'b0000, inc};
    end

endmodule

// File: rtl/sqroot_req_fifo.sv
// Request FIFO: DEPTH entries of W bits, head always visible on the output.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: full blocks pushes, empty blocks pops; no bypass through a full FIFO.
module sqroot_req_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage writes at the write pointer; cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sqroot_stream_stage.sv
// Streaming wrapper around a combinational square root: request FIFO in, result register out.
// Latency: result valid one cycle after the accepting edge when the FIFO was empty.
// Backpressure: in_ready is FIFO not-full only; out_ready stalls pops, holding the result.
module sqroot_stream_stage
    import sqroot_pkg::*;
#(
    parameter int NBITS = SQ_NBITS,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NBITS-1:0]           in_arg,
    input  logic                       in_roundup,
    output logic [NBITS-1:0]           root_arg,
    output logic                       root_roundup,
    input  logic [root_w(NBITS)-1:0]   root_sqroot,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [root_w(NBITS)-1:0]   out_sqroot,
    output logic [NBITS-1:0]           out_arg,
    output logic [$clog2(DEPTH):0]     level
);

    typedef struct packed {
        logic             roundup;
        logic [NBITS-1:0] arg;
    } req_t;

    if ((NBITS % 2) != 0 || NBITS < 4) begin : g_bad_nbits
        $error("sqroot_stream_stage: NBITS must be even and >= 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sqroot_stream_stage: DEPTH must be a power of two >= 2");
    end

    req_t push_req;
    req_t head_req;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign push_req = '{roundup: in_roundup, arg: in_arg};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // Pop whenever the result register is free now or is being drained this cycle.
    assign pop      = !fifo_empty && (!out_valid || out_ready);

    sqroot_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head_req),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head goes straight to the root; forced to zero when empty so the root stays quiet.
    always_comb begin
        root_arg     = '0;
        root_roundup = 1'b0;
        if (!fifo_empty) begin
            root_arg     = head_req.arg;
            root_roundup = head_req.roundup;
        end
    end

    // Result register: load on pop, drop valid on a drain with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sqroot <= '0;
            out_arg    <= '0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_sqroot <= root_sqroot;
            out_arg    <= head_req.arg;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sqroot_stream_stage.sv
// Bench for sqroot_stream_stage with the 8-bit combinational root between root_* and root_sqroot.
// A queue model of in-flight requests checks level, in_ready, root_* and each delivered result.
// Directed literal checks pin latency, extremes, backpressure order and asynchronous reset.
module tb_sqroot_stream_stage;
    import sqroot_pkg::*;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_arg;
    logic       in_roundup;
    logic [7:0] root_arg;
    logic       root_roundup;
    logic [4:0] root_sqroot;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sqroot;
    logic [7:0] out_arg;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;
    int res_cnt = 0;
    sqroot_req_t q[$];
    logic       prev_hold = 1'b0;
    logic [4:0] prev_sq;
    logic [7:0] prev_arg;

    sqroot_stream_stage #(.NBITS(NB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_arg       (in_arg),
        .in_roundup   (in_roundup),
        .root_arg     (root_arg),
        .root_roundup (root_roundup),
        .root_sqroot  (root_sqroot),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sqroot   (out_sqroot),
        .out_arg      (out_arg),
        .level        (level)
    );

    sqroot_comb_NBITS8 u_root (
        .arg     (root_arg),
        .roundup (root_roundup),
        .sqroot  (root_sqroot)
    );

    always #5 clk = ~clk;

    // Reference root from real arithmetic: floor(sqrt) or nearest integer to sqrt.
    function automatic int ref_root(input int a, input bit ru);
        real s;
        s = $sqrt(real'(a));
        return ru ? $rtoi(s + 0.5) : $rtoi(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Called at posedge+1; holds the request until it is taken, returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] a, input logic ru);
        int n;
        n = 0;
        in_valid   = 1'b1;
        in_arg     = a;
        in_roundup = ru;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Model: every accepted request joins the queue; every output handshake retires the oldest.
    always @(negedge clk) begin
        int          occ;
        sqroot_req_t hd;
        sqroot_req_t e;
        if (rst) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            occ = q.size() - (out_valid ? 1 : 0);
            check("level", int'(level), occ);
            check("in_ready", int'(in_ready), int'(occ != DEPTH));
            hd = '0;
            if (occ > 0) hd = q[out_valid ? 1 : 0];
            check("root_arg", int'(root_arg), int'(hd.arg));
            check("root_roundup", int'(root_roundup), int'(hd.roundup));
            if (prev_hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_sqroot", int'(out_sqroot), int'(prev_sq));
                check("hold_arg", int'(out_arg), int'(prev_arg));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = q.pop_front();
                    check("out_sqroot", int'(out_sqroot), ref_root(int'(e.arg), e.roundup));
                    check("out_arg", int'(out_arg), int'(e.arg));
                    res_cnt++;
                end
            end
            if (in_valid && in_ready) q.push_back('{roundup: in_roundup, arg: in_arg});
            prev_hold = out_valid && !out_ready;
            prev_sq   = out_sqroot;
            prev_arg  = out_arg;
        end
    end

    sqroot_req_t singles [6];
    int          single_exp [6];
    logic [7:0]  bp_args [6];
    int          bp_exp [6];

    initial begin
        int  res_before;
        int  maxlvl;
        int  ov_cycles;
        int  sent;
        int  cyc;
        int  n;
        logic acc_pending;
        logic drop;

        singles[0] = '{roundup: 1'b0, arg: 8'd16};  single_exp[0] = 4;
        singles[1] = '{roundup: 1'b1, arg: 8'd24};  single_exp[1] = 5;
        singles[2] = '{roundup: 1'b1, arg: 8'd20};  single_exp[2] = 4;
        singles[3] = '{roundup: 1'b0, arg: 8'd255}; single_exp[3] = 15;
        singles[4] = '{roundup: 1'b1, arg: 8'd255}; single_exp[4] = 16;
        singles[5] = '{roundup: 1'b1, arg: 8'd0};   single_exp[5] = 0;
        bp_args[0] = 8'd0;  bp_args[1] = 8'd1;  bp_args[2] = 8'd4;
        bp_args[3] = 8'd9;  bp_args[4] = 8'd15; bp_args[5] = 8'd255;
        bp_exp[0] = 0; bp_exp[1] = 1; bp_exp[2] = 2; bp_exp[3] = 3; bp_exp[4] = 3; bp_exp[5] = 15;

        rst = 1'b1; in_valid = 1'b0; in_arg = '0; in_roundup = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sqroot", int'(out_sqroot), 0);
        check("rst_out_arg", int'(out_arg), 0);
        check("rst_root_arg", int'(root_arg), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single requests: result valid exactly one edge after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(singles[i].arg, singles[i].roundup);
            check("lat_not_yet", int'(out_valid), 0);
            @(posedge clk); #1;
            check("lat_valid", int'(out_valid), 1);
            check("single_sqroot", int'(out_sqroot), single_exp[i]);
            check("single_arg", int'(out_arg), int'(singles[i].arg));
        end
        repeat (2) @(posedge clk); #1;

        // Backpressure: five accepted, the sixth stalls with the FIFO full.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(bp_args[i], 1'b0);
        in_valid = 1'b1; in_arg = bp_args[5]; in_roundup = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_level", int'(level), 4);
            check("bp_valid", int'(out_valid), 1);
            check("bp_sqroot", int'(out_sqroot), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("bp_rel_valid", int'(out_valid), 1);
            check("bp_rel_sqroot", int'(out_sqroot), bp_exp[j]);
            drop = in_valid && in_ready;
            @(posedge clk); #1;
            if (drop) in_valid = 1'b0;
        end
        check("bp_sixth_taken", int'(in_valid), 0);
        repeat (3) @(posedge clk); #1;

        // Streaming all 256 operands back to back.
        res_before = res_cnt; maxlvl = 0; ov_cycles = 0;
        for (int a = 0; a < 256; a++) begin
            in_valid = 1'b1; in_arg = 8'(a); in_roundup = a[0];
            @(negedge clk);
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (out_valid) ov_cycles++;
            check("stream_in_ready", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("stream_results", res_cnt - res_before, 256);
        check("stream_max_level_le1", int'(maxlvl <= 1), 1);
        check("stream_valid_cycles", ov_cycles, 254);

        // Asynchronous reset while busy.
        out_ready = 1'b0;
        send(8'd100, 1'b0); send(8'd50, 1'b0); send(8'd20, 1'b0); send(8'd9, 1'b0);
        check("pre_rst_level", int'(level), 3);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_sqroot", int'(out_sqroot), 10);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_level", int'(level), 0);
        check("arst_sqroot", int'(out_sqroot), 0);
        check("arst_arg", int'(out_arg), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_root_arg", int'(root_arg), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'd99, 1'b1);
        @(posedge clk); #1;
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_sqroot", int'(out_sqroot), 10);
        check("post_rst_arg", int'(out_arg), 99);
        repeat (2) @(posedge clk); #1;

        // Random valid/ready traffic, 2000 requests.
        res_before = res_cnt; sent = 0; cyc = 0; acc_pending = 1'b0;
        while (sent < 2000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (acc_pending) begin
                in_valid = 1'b0;
                sent++;
                acc_pending = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_arg = 8'($urandom); in_roundup = 1'($urandom);
            end
            @(negedge clk);
            acc_pending = in_valid && in_ready;
            cyc++;
        end
        if (sent < 2000) fail_now("random_timeout");
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("random_drained", q.size(), 0);
        check("random_results", res_cnt - res_before, sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
